// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared CPU constants for the MEM stage: reset PC, load-op
//               encodings, MEM FSM state codes and the stage-register layout.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    localparam logic [2:0] c_LOAD_LW  = 3'b000;
    localparam logic [2:0] c_LOAD_LB  = 3'b001;
    localparam logic [2:0] c_LOAD_LBU = 3'b010;
    localparam logic [2:0] c_LOAD_LH  = 3'b011;
    localparam logic [2:0] c_LOAD_LHU = 3'b100;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_HELD = 2'd2;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] result;
        logic        is_load;
        logic [2:0]  load_op;
        logic        reg_en;
        logic [4:0]  dest;
    } mem_ctx_t;

    // PC is seeded one word before the boot vector so IF's first +4 lands on it
    localparam mem_ctx_t c_CTX_RESET = '{
        inst:    32'd0,
        pc:      RESET_PC - 32'd4,
        result:  32'd0,
        is_load: 1'b0,
        load_op: 3'd0,
        reg_en:  1'b0,
        dest:    5'd0
    };

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_if
// Description : EX/WB handshake, data-memory response and forwarding bundle
//               of the MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if;

    logic        ex_valid;
    logic        mem_allow_in;
    logic [31:0] ex_inst;
    logic [31:0] ex_pc;
    logic [31:0] ex_result;
    logic        ex_is_load;
    logic [2:0]  ex_load_op;
    logic        ex_reg_en;
    logic [4:0]  ex_dest;

    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    logic        wb_allow_in;
    logic        mem_ready_go;
    logic [31:0] mem_inst;
    logic [31:0] mem_pc;
    logic [31:0] mem_data_to_reg;
    logic        mem_reg_en;
    logic [4:0]  mem_dest;

    logic        fwd_we;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;
    logic        fwd_load_stall;

    modport master (
        output ex_valid, ex_inst, ex_pc, ex_result, ex_is_load, ex_load_op,
               ex_reg_en, ex_dest, data_sram_data_ok, data_sram_rdata, wb_allow_in,
        input  mem_allow_in, mem_ready_go, mem_inst, mem_pc, mem_data_to_reg,
               mem_reg_en, mem_dest, fwd_we, fwd_dest, fwd_data, fwd_load_stall
    );

    modport slave (
        input  ex_valid, ex_inst, ex_pc, ex_result, ex_is_load, ex_load_op,
               ex_reg_en, ex_dest, data_sram_data_ok, data_sram_rdata, wb_allow_in,
        output mem_allow_in, mem_ready_go, mem_inst, mem_pc, mem_data_to_reg,
               mem_reg_en, mem_dest, fwd_we, fwd_dest, fwd_data, fwd_load_stall
    );

endinterface
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects and extends the addressed byte/half of a load word.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  op,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (offset)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        // Halves are naturally aligned; the low offset bit carries no meaning
        w_half = offset[1] ? rdata[31:16] : rdata[15:0];

        case (op)
            c_LOAD_LB:  result = {{24{w_byte[7]}}, w_byte};
            c_LOAD_LBU: result = {24'd0, w_byte};
            c_LOAD_LH:  result = {{16{w_half[15]}}, w_half};
            c_LOAD_LHU: result = {16'd0, w_half};
            default:    result = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline MEM stage: holds one instruction, waits for load
//               data, aligns it and offers the result to WB and to ID bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus
);

    logic        r_valid;
    logic [1:0]  r_state;
    mem_ctx_t    r_ctx;
    logic [31:0] r_buf;

    mem_ctx_t    w_ex_ctx;
    logic        w_ready_go;
    logic        w_allow_in;
    logic        w_accept;
    logic        w_new_load;
    logic [31:0] w_raw;
    logic [31:0] w_load_data;
    logic [31:0] w_data_to_reg;

    always_comb begin
        w_ex_ctx = '{
            inst:    bus.ex_inst,
            pc:      bus.ex_pc,
            result:  bus.ex_result,
            is_load: bus.ex_is_load,
            load_op: bus.ex_load_op,
            reg_en:  bus.ex_reg_en,
            dest:    bus.ex_dest
        };
        w_ready_go = !r_ctx.is_load
                   | ((r_state == c_ST_WAIT) & bus.data_sram_data_ok)
                   | (r_state == c_ST_HELD);
        w_allow_in = !r_valid | (w_ready_go & bus.wb_allow_in);
        w_accept   = bus.ex_valid & w_allow_in;
        w_new_load = w_accept & bus.ex_is_load;
        w_raw      = (r_state == c_ST_HELD) ? r_buf : bus.data_sram_rdata;
        w_data_to_reg = r_ctx.is_load ? w_load_data : r_ctx.result;
    end

    load_align u_load_align (
        .rdata  (w_raw),
        .offset (r_ctx.result[1:0]),
        .op     (r_ctx.load_op),
        .result (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_state <= c_ST_IDLE;
            r_ctx   <= c_CTX_RESET;
            r_buf   <= 32'd0;
        end else begin
            if (w_allow_in)
                r_valid <= bus.ex_valid;
            if (w_accept)
                r_ctx <= w_ex_ctx;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_new_load)
                        r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (bus.data_sram_data_ok) begin
                        if (bus.wb_allow_in) begin
                            r_state <= w_new_load ? c_ST_WAIT : c_ST_IDLE;
                        end else begin
                            // WB stalled: keep the raw word, the SRAM won't repeat it
                            r_state <= c_ST_HELD;
                            r_buf   <= bus.data_sram_rdata;
                        end
                    end
                end
                c_ST_HELD: begin
                    if (bus.wb_allow_in)
                        r_state <= w_new_load ? c_ST_WAIT : c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.mem_allow_in    = w_allow_in;
    assign bus.mem_ready_go    = r_valid & w_ready_go;
    assign bus.mem_inst        = r_ctx.inst;
    assign bus.mem_pc          = r_ctx.pc;
    assign bus.mem_data_to_reg = w_data_to_reg;
    assign bus.mem_reg_en      = r_ctx.reg_en;
    assign bus.mem_dest        = r_ctx.dest;

    assign bus.fwd_we          = r_valid & r_ctx.reg_en & w_ready_go;
    assign bus.fwd_dest        = r_ctx.dest;
    assign bus.fwd_data        = w_data_to_reg;
    assign bus.fwd_load_stall  = r_valid & r_ctx.is_load & r_ctx.reg_en & !w_ready_go;

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have EX-side ports: ex_valid in 1 (EX offers an instruction); mem_allow_in out 1 (MEM accepts this cycle); ex_inst in 32; ex_pc in 32; ex_result in 32 (ALU result or load address); ex_is_load in 1; ex_load_op in 3; ex_reg_en in 1; ex_dest in 5.
REQ-003 SHALL have data-memory response ports: data_sram_data_ok in 1 (read data valid, one pulse per load); data_sram_rdata in 32.
REQ-004 SHALL have WB-side ports: wb_allow_in in 1; mem_ready_go out 1 (offer to WB, already qualified with valid); mem_inst out 32; mem_pc out 32; mem_data_to_reg out 32; mem_reg_en out 1; mem_dest out 5.
REQ-005 SHALL have forwarding ports: fwd_we out 1; fwd_dest out 5; fwd_data out 32; fwd_load_stall out 1 (ID must stall on a match).

Function
REQ-006 An instruction SHALL transfer EX->MEM when ex_valid & mem_allow_in; the stage register captures all ex_* fields on that edge.
REQ-007 valid SHALL be loaded with ex_valid whenever mem_allow_in=1, and held otherwise.
REQ-008 mem_allow_in SHALL equal !valid | (ready_go & wb_allow_in), combinationally.
REQ-009 Internal ready_go SHALL be 1 for a valid non-load; for a load, 1 only in the data_ok cycle or in state HELD.
REQ-010 mem_ready_go SHALL equal valid & ready_go; a transfer to WB occurs when mem_ready_go & wb_allow_in.
REQ-011 FSM states: IDLE (no load pending), WAIT (valid load, no data yet), HELD (data captured, WB not yet taken).
REQ-012 Transitions: load accepted -> WAIT; WAIT & data_ok & wb_allow_in -> IDLE, or WAIT if a new load is accepted the same edge; WAIT & data_ok & !wb_allow_in -> HELD, data_sram_rdata captured into buffer; HELD & wb_allow_in -> IDLE/WAIT as above.
REQ-013 data_ok while in IDLE or HELD SHALL be ignored; no state or data change.
REQ-014 In the data_ok cycle, read data SHALL pass combinationally to mem_data_to_reg; from HELD, the buffered word is used.
REQ-015 Load extraction using ex_result[1:0] (offset): LW 000 full word; LB 001 byte[offset] sign-extended; LBU 010 byte zero-extended; LH 011 half[offset[1]] sign-extended; LHU 100 zero-extended; offset[0] ignored for halves; other codes SHALL yield the full word.
REQ-016 For a non-load, mem_data_to_reg SHALL equal the stored ex_result.
REQ-017 fwd_we = valid & reg_en & ready_go; fwd_dest = stored dest; fwd_data = mem_data_to_reg.
REQ-018 fwd_load_stall = valid & is_load & reg_en & !ready_go.
REQ-019 Back-to-back loads SHALL sustain one per cycle when data_ok arrives in each load's first MEM cycle and wb_allow_in=1.

Reset
REQ-020 On reset: valid=0; state=IDLE; inst, result and buffer =0; pc=RESET_PC-4 (0x1bfffffc); reg_en=0; dest=0.
REQ-021 Outputs after reset: mem_ready_go=0, mem_allow_in=1, fwd_we=0, fwd_load_stall=0.
REQ-022 Reset mid-load SHALL discard the pending load; a later stray data_ok SHALL be ignored per REQ-013.

Structure
REQ-023 Load-op encodings and RESET_PC SHALL be in the shared CPU package.
REQ-024 Extraction SHALL be a combinational sub-module load_align (rdata, offset, op -> 32-bit result).
REQ-025 Target 150-250 lines of RTL.

Verification
REQ-026 ALU op: pc=0x1c000000, result=0x12345678, dest=5, reg_en=1 -> next cycle mem_ready_go=1, fwd_we=1, fwd_data=0x12345678.
REQ-027 LB at addr 0x...3 with rdata=0x80FF7F01, data_ok in first cycle -> data_to_reg=0xFFFFFF80; LBU -> 0x00000080.
REQ-028 LH at addr 0x...2 with rdata=0x8001FFFF, data_ok after 3 cycles -> fwd_load_stall=1 for 3 cycles, mem_allow_in=0, then data_to_reg=0xFFFF8001.
REQ-029 data_ok with wb_allow_in=0 -> HELD; rdata changes to 0xDEADBEEF -> output keeps original word until WB accepts.
REQ-030 Reset asserted in WAIT, then stray data_ok -> valid stays 0, no WB transfer.
REQ-031 Four back-to-back LW, each with data_ok in its first cycle -> four consecutive WB transfers, zero bubbles.
